dac7611_rx: RTL and testbench

DAC7611_RX -- requirements
Module: dac7611_rx

---
 rtl/dac7611_rx.sv | 153 +++++++++++++++
 tb/tb_dac7611_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dac7611_rx.sv
// DAC7611-style serial receiver: synchronizes the 3-wire serial port plus clear,
// shifts the code in MSB first and latches it into the DAC register on the load strobe.
module dac7611_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CODE_W      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ser_clk,
    input  logic              ser_sdi,
    input  logic              ser_ld,
    input  logic              ser_clr,
    output logic [CODE_W-1:0] dac_code,
    output logic              code_valid,
    output logic              frame_err,
    output logic [3:0]        bit_count,
    output logic              busy
);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_LOAD  = 2'd3;

    localparam logic [3:0] FULL_CNT = 4'(CODE_W);

    // Line order: 0 = clk, 1 = sdi, 2 = ld, 3 = clr
    logic [3:0] pins;
    logic [3:0] sync_s;
    logic [3:0] prev_q;

    assign pins = {ser_clr, ser_ld, ser_sdi, ser_clk};

    // Every line idles high, so the chains reset to 1 and no edge appears after reset.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    chain_q <= '1;
                end else begin
                    chain_q <= {chain_q[SYNC_STAGES-2:0], pins[gi]};
                end
            end
            assign sync_s[gi] = chain_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '1;
        end else begin
            prev_q <= sync_s;
        end
    end

    logic clk_rise;
    logic ld_fall;
    logic sdi_s;
    logic ld_s;
    logic clr_s;
    logic qual_rise;
    logic unused_prev;

    assign clk_rise    = sync_s[0] & ~prev_q[0];
    assign ld_fall     = ~sync_s[2] & prev_q[2];
    assign sdi_s       = sync_s[1];
    assign ld_s        = sync_s[2];
    assign clr_s       = sync_s[3];
    assign unused_prev = prev_q[1] ^ prev_q[3];

    logic [1:0]        state_q, state_d;
    logic [CODE_W-1:0] shift_q, shift_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    // A clock rise in the same cycle as the load fall still counts, so the
    // final bit lands in the register before LOAD copies it out.
    assign qual_rise = clk_rise & clr_s & (ld_s | ld_fall) &
                       ((state_q == S_IDLE) | (state_q == S_SHIFT));

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (!clr_s) begin
            state_d = S_CLEAR;
            shift_d = '0;
            code_d  = '0;
            cnt_d   = '0;
        end else begin
            if (qual_rise) begin
                shift_d = {shift_q[CODE_W-2:0], sdi_s};
                if (cnt_q != 4'hF) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            case (state_q)
                S_CLEAR: state_d = S_IDLE;
                S_IDLE: begin
                    if (ld_fall) begin
                        state_d = S_LOAD;
                    end else if (qual_rise) begin
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ld_fall) begin
                        state_d = S_LOAD;
                    end
                end
                default: begin
                    code_d  = shift_q;
                    valid_d = 1'b1;
                    err_d   = (cnt_q != FULL_CNT);
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_CLEAR;
            shift_q <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign dac_code   = code_q;
    assign code_valid = valid_q;
    assign frame_err  = err_q;
    assign bit_count  = cnt_q;
    assign busy       = (state_q == S_SHIFT);

endmodule

// File: tb/tb_dac7611_rx.sv
// Directed bench for dac7611_rx: expected loads are queued as the strobe is driven
// and checked, together with their latency, when code_valid pulses.
module tb_dac7611_rx;

    localparam int SYNC = 2;
    localparam int CW   = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ser_clk = 1'b1;
    logic          ser_sdi = 1'b1;
    logic          ser_ld = 1'b1;
    logic          ser_clr = 1'b1;
    logic [CW-1:0] dac_code;
    logic          code_valid;
    logic          frame_err;
    logic [3:0]    bit_count;
    logic          busy;

    dac7611_rx #(.SYNC_STAGES(SYNC), .CODE_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ser_clk    (ser_clk),
        .ser_sdi    (ser_sdi),
        .ser_ld     (ser_ld),
        .ser_clr    (ser_clr),
        .dac_code   (dac_code),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .bit_count  (bit_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] code;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   loads_issued = 0;
    int   valid_seen = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every code_valid pulse must match the oldest queued load.
    always @(negedge clk) begin
        if (code_valid === 1'b1) begin
            exp_t e;
            valid_seen++;
            chk("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("dac_code", 32'(dac_code), 32'(e.code));
                chk("frame_err", 32'(frame_err), 32'(e.err));
                chk("latency", 32'(cyc - e.cyc), 32'(SYNC + 2));
                $display("load: code=%03h err=%0b latency=%0d", dac_code, frame_err, cyc - e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_clk = 1'b0;
        ser_sdi = b;
        tick(2);
        ser_clk = 1'b1;
        tick(2);
    endtask

    task automatic send_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(val[i]);
    endtask

    task automatic push_exp(input logic [CW-1:0] code, input logic err);
        exp_t e;
        e.code = code;
        e.err  = err;
        e.cyc  = cyc;
        exp_q.push_back(e);
        loads_issued++;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 16 && exp_q.size() != 0; i++) tick(1);
        chk("load_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick(2);
    endtask

    task automatic do_load(input logic [CW-1:0] code, input logic err);
        push_exp(code, err);
        ser_ld = 1'b0;
        tick(2);
        ser_ld = 1'b1;
        wait_drain();
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_dac_code", 32'(dac_code), 32'h0);
        chk("rst_code_valid", 32'(code_valid), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_bit_count", 32'(bit_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        tick(4);

        // Clear, with a load strobe inside the clear that must be ignored, then 0x555
        ser_clr = 1'b0;
        tick(2);
        ser_ld = 1'b0;
        tick(2);
        ser_ld = 1'b1;
        tick(3);
        ser_clr = 1'b1;
        tick(4);
        send_bits(32'h555, 12);
        tick(2);
        chk("cnt_before_555", 32'(bit_count), 32'd12);
        chk("busy_shift", 32'(busy), 32'd1);
        do_load(12'h555, 1'b0);
        chk("cnt_after_load", 32'(bit_count), 32'd0);
        chk("busy_after_load", 32'(busy), 32'd0);

        // Partial frame aborted by clear, then 0xABC
        send_bits(32'h2D, 6);
        ser_clr = 1'b0;
        tick(2);
        ser_clr = 1'b1;
        tick(4);
        chk("clr_dac_code", 32'(dac_code), 32'h0);
        chk("clr_bit_count", 32'(bit_count), 32'h0);
        send_bits(32'hABC, 12);
        do_load(12'hABC, 1'b0);

        // 14-bit frame keeps the last 12 bits
        send_bits(32'h30F0, 14);
        tick(2);
        chk("cnt_14", 32'(bit_count), 32'd14);
        do_load(12'h0F0, 1'b1);

        // Short frame on top of a retained shift register
        send_bits(32'h555, 12);
        do_load(12'h555, 1'b0);
        send_bits(32'hFF, 8);
        do_load(12'h5FF, 1'b1);

        // Count saturation
        send_bits(32'hFFFF, 16);
        tick(2);
        chk("cnt_saturate", 32'(bit_count), 32'd15);
        do_load(12'hFFF, 1'b1);

        // Load with no bits shifted
        do_load(12'hFFF, 1'b1);

        // Last clock rise and load fall in the same synchronized cycle
        send_bits(32'h2A5 >> 1, 11);
        ser_clk = 1'b0;
        ser_sdi = 1'b1;
        tick(2);
        push_exp(12'h2A5, 1'b0);
        ser_clk = 1'b1;
        ser_ld = 1'b0;
        tick(2);
        ser_ld = 1'b1;
        wait_drain();
        chk("cnt_after_same", 32'(bit_count), 32'd0);

        // Asynchronous reset mid-frame, outputs clear before the next clock edge
        send_bits(32'h15, 5);
        #2;
        reset = 1'b1;
        #1;
        chk("async_dac_code", 32'(dac_code), 32'h0);
        chk("async_bit_count", 32'(bit_count), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_valid", 32'(code_valid), 32'h0);
        chk("async_err", 32'(frame_err), 32'h0);
        tick(2);
        reset = 1'b0;
        tick(4);
        send_bits(32'h3C3, 12);
        do_load(12'h3C3, 1'b0);

        tick(8);
        chk("valid_pulses", 32'(valid_seen), 32'(loads_issued));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
